uart_link_fabric: RTL and testbench

Synthesizable, parametrised UART line fabric that replaces the fixed single-channel tx-to-rx loopback in the HDL top. It routes each destination `rx` line from any source `tx` line. Each route has a programmable line delay in `pclk` cycles. Route changes are deferred until both the old and the new source lines are quiescent, so no frame is corrupted in flight. It sits between the `uart_if` instances and the device agent BFMs.

---
 rtl/uart_link_pkg.sv | 21 ++
 rtl/uart_link_fabric_if.sv | 28 ++
 rtl/uart_link_delay.sv | 50 +++++
 rtl/uart_link_fabric.sv | 140 ++++++++++++++
 tb/tb_uart_link_fabric.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared types and defaults for the UART link fabric
package uart_link_pkg;

    typedef enum logic {
        LINK_ACTIVE  = 1'b0,
        LINK_PENDING = 1'b1
    } link_state_e;

    localparam int LINK_DEF_NUM_CH      = 2;
    localparam int LINK_DEF_DELAY_W     = 4;
    localparam int LINK_DEF_IDLE_CYCLES = 32;

    // Reset route is an identity loopback with no added delay
    localparam logic LINK_RST_EN    = 1'b1;
    localparam int   LINK_RST_DELAY = 0;

    function automatic int link_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_link_fabric_if.sv
// rtl/uart_link_fabric_if.sv - route configuration handshake and pending status
interface uart_link_fabric_if
    import uart_link_pkg::*;
#(
    parameter int NUM_CH  = LINK_DEF_NUM_CH,
    parameter int DELAY_W = LINK_DEF_DELAY_W
);
    localparam int CH_W = link_idx_w(NUM_CH);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [CH_W-1:0]    cfg_src;
    logic [DELAY_W-1:0] cfg_delay;
    logic               cfg_en;
    logic [NUM_CH-1:0]  pending;

    modport master (
        output cfg_valid, cfg_ch, cfg_src, cfg_delay, cfg_en,
        input  cfg_ready, pending
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_src, cfg_delay, cfg_en,
        output cfg_ready, pending
    );

endinterface

// File: rtl/uart_link_delay.sv
// rtl/uart_link_delay.sv - per-source delay line taps and idle-quiescence detector
module uart_link_delay
    import uart_link_pkg::*;
#(
    parameter int DELAY_W     = LINK_DEF_DELAY_W,
    parameter int IDLE_CYCLES = LINK_DEF_IDLE_CYCLES
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  tx,
    output logic [2**DELAY_W-1:0] taps,
    output logic                  quiet
);
    localparam int DMAX  = 2**DELAY_W - 1;
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    if (DELAY_W < 1) begin : g_bad_delay_w
        $error("uart_link_delay: DELAY_W must be at least 1");
    end
    // A quiet source must guarantee the whole delay line is idle-high
    if (IDLE_CYCLES < DMAX + 2) begin : g_bad_idle
        $error("uart_link_delay: IDLE_CYCLES must be >= 2**DELAY_W + 1");
    end

    logic [DMAX-1:0]  sh;
    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sh       <= '1;
            idle_cnt <= IDLE_MAX;
        end else begin
            sh[0] <= tx;
            for (int k = 1; k < DMAX; k++) begin
                sh[k] <= sh[k-1];
            end
            if (!tx) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Tap 0 is the live line so the registered rx gives delay+1 latency
    assign taps  = {sh, tx};
    assign quiet = (idle_cnt == IDLE_MAX);

endmodule

// File: rtl/uart_link_fabric.sv
// rtl/uart_link_fabric.sv - routes delayed tx lines to rx with deferred route updates (option: UART_LINK_FAULT_EN)
module uart_link_fabric
    import uart_link_pkg::*;
#(
    parameter int NUM_CH      = LINK_DEF_NUM_CH,
    parameter int DELAY_W     = LINK_DEF_DELAY_W,
    parameter int IDLE_CYCLES = LINK_DEF_IDLE_CYCLES
) (
    input  logic              pclk,
    input  logic              areset,
    input  logic [NUM_CH-1:0] tx,
    output logic [NUM_CH-1:0] rx,
`ifdef UART_LINK_FAULT_EN
    input  logic [NUM_CH-1:0] fault_flip,
`endif
    uart_link_fabric_if.slave cfg
);
    localparam int CH_W  = link_idx_w(NUM_CH);
    localparam int NSLOT = 2**CH_W;
    localparam int TAP_N = 2**DELAY_W;

    typedef struct packed {
        logic               en;
        logic [CH_W-1:0]    src;
        logic [DELAY_W-1:0] delay;
    } route_t;

    // Source-indexed tables padded to the full index range; unused slots look idle
    logic [TAP_N-1:0] taps [NSLOT];
    logic [NSLOT-1:0] quiet;

    for (genvar s = 0; s < NSLOT; s++) begin : g_src
        if (s < NUM_CH) begin : g_line
            uart_link_delay #(
                .DELAY_W     (DELAY_W),
                .IDLE_CYCLES (IDLE_CYCLES)
            ) u_delay (
                .pclk   (pclk),
                .areset (areset),
                .tx     (tx[s]),
                .taps   (taps[s]),
                .quiet  (quiet[s])
            );
        end else begin : g_none
            assign taps[s]  = '1;
            assign quiet[s] = 1'b1;
        end
    end

    link_state_e       state     [NUM_CH];
    link_state_e       state_nxt [NUM_CH];
    route_t            active    [NUM_CH];
    route_t            shadow    [NUM_CH];
    route_t            new_route;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] routed;
    logic [NSLOT-1:0]  slot_ready;
    logic [NSLOT-1:0]  src_ok;
    logic              cfg_fire;

    always_comb begin
        slot_ready = '1;
        src_ok     = '0;
        src_ok[NUM_CH-1:0] = '1;
        for (int d = 0; d < NUM_CH; d++) begin
            slot_ready[d] = (state[d] == LINK_ACTIVE);
        end
    end

    // Out-of-range channels always accept and are simply never matched below
    assign cfg.cfg_ready = slot_ready[cfg.cfg_ch];
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        new_route.en    = cfg.cfg_en & src_ok[cfg.cfg_src];
        new_route.src   = cfg.cfg_src;
        new_route.delay = cfg.cfg_delay;
    end

    always_comb begin
        state_nxt = state;
        accept    = '0;
        apply     = '0;
        for (int d = 0; d < NUM_CH; d++) begin
            case (state[d])
                LINK_ACTIVE: begin
                    if (cfg_fire && (cfg.cfg_ch == CH_W'(d))) begin
                        accept[d]    = 1'b1;
                        state_nxt[d] = LINK_PENDING;
                    end
                end
                LINK_PENDING: begin
                    if ((!active[d].en || quiet[active[d].src]) &&
                        (!shadow[d].en || quiet[shadow[d].src])) begin
                        apply[d]     = 1'b1;
                        state_nxt[d] = LINK_ACTIVE;
                    end
                end
                default: state_nxt[d] = LINK_ACTIVE;
            endcase
        end
    end

    always_comb begin
        routed      = '1;
        cfg.pending = '0;
        for (int d = 0; d < NUM_CH; d++) begin
            routed[d]      = active[d].en ? taps[active[d].src][active[d].delay] : 1'b1;
            cfg.pending[d] = (state[d] == LINK_PENDING);
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rx <= '1;
            for (int d = 0; d < NUM_CH; d++) begin
                state[d]  <= LINK_ACTIVE;
                active[d] <= '{en: LINK_RST_EN, src: CH_W'(d), delay: DELAY_W'(LINK_RST_DELAY)};
                shadow[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_CH; d++) begin
                state[d] <= state_nxt[d];
                if (accept[d]) begin
                    shadow[d] <= new_route;
                end
                if (apply[d]) begin
                    active[d] <= shadow[d];
                end
`ifdef UART_LINK_FAULT_EN
                rx[d] <= routed[d] ^ fault_flip[d];
`else
                rx[d] <= routed[d];
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_link_fabric.sv
// tb/tb_uart_link_fabric.sv - randomized scoreboard bench for uart_link_fabric
module tb_uart_link_fabric;
    localparam int NUM_CH      = 3;
    localparam int DELAY_W     = 4;
    localparam int IDLE_CYCLES = 20;
    localparam int NCYC        = 4000;
    localparam int BP          = 3;

    logic              pclk = 1'b0;
    logic              areset;
    logic [NUM_CH-1:0] tx;
    logic [NUM_CH-1:0] rx;
    logic [NUM_CH-1:0] flip;
`ifdef UART_LINK_FAULT_EN
    logic [NUM_CH-1:0] fault_flip;
    assign fault_flip = flip;
`endif

    uart_link_fabric_if #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W)) cfg ();

    uart_link_fabric #(
        .NUM_CH      (NUM_CH),
        .DELAY_W     (DELAY_W),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .pclk       (pclk),
        .areset     (areset),
        .tx         (tx),
        .rx         (rx),
`ifdef UART_LINK_FAULT_EN
        .fault_flip (fault_flip),
`endif
        .cfg        (cfg)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] rx;
        logic [NUM_CH-1:0] pending;
        logic              ready;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: a line's output is its source's history shifted by delay+1;
    // a source is quiet when its last IDLE_CYCLES samples were all high.
    logic hist [NUM_CH][NCYC];
    int   last_rst = -1;
    bit   m_en  [NUM_CH];
    int   m_src [NUM_CH];
    int   m_dly [NUM_CH];
    bit   s_en  [NUM_CH];
    int   s_src [NUM_CH];
    int   s_dly [NUM_CH];
    bit   m_pend[NUM_CH];
    logic [NUM_CH-1:0] m_rx;
    logic txq [NUM_CH][$];

    function automatic logic tx_at(int s, int j);
        if (j < 0 || j <= last_rst) return 1'b1;
        return hist[s][j];
    endfunction

    function automatic bit quiet_at(int s, int c);
        for (int j = c - IDLE_CYCLES; j < c; j++) begin
            if (!tx_at(s, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit model_ready(int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    task automatic model_reset(int c);
        for (int d = 0; d < NUM_CH; d++) begin
            m_en[d] = 1'b1; m_src[d] = d; m_dly[d] = 0;
            s_en[d] = 1'b0; s_src[d] = 0; s_dly[d] = 0;
            m_pend[d] = 1'b0;
        end
        m_rx = '1;
        last_rst = c;
    endtask

    task automatic model_step(int c, bit fire, int ch, int src, int dly, bit en);
        if (!areset) begin
            model_reset(c);
            return;
        end
        for (int d = 0; d < NUM_CH; d++) begin
            m_rx[d] = (m_en[d] ? tx_at(m_src[d], c - m_dly[d]) : 1'b1) ^ flip[d];
        end
        for (int d = 0; d < NUM_CH; d++) begin
            if (m_pend[d]) begin
                if ((!m_en[d] || quiet_at(m_src[d], c)) && (!s_en[d] || quiet_at(s_src[d], c))) begin
                    m_en[d] = s_en[d]; m_src[d] = s_src[d]; m_dly[d] = s_dly[d];
                    m_pend[d] = 1'b0;
                end
            end else if (fire && ch == d) begin
                s_en[d]  = en && (src < NUM_CH);
                s_src[d] = src;
                s_dly[d] = dly;
                m_pend[d] = 1'b1;
            end
        end
    endtask

    task automatic push_frame(int s, logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < BP; k++) txq[s].push_back(bits[i]);
        end
    endtask

    always @(negedge pclk) begin
        if (sb.size() > 0) begin : mon
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rx !== e.rx) begin
                errors++;
                $display("FAIL rx cyc=%0d got=%b exp=%b", e.cyc, rx, e.rx);
            end
            checks++;
            if (cfg.pending !== e.pending) begin
                errors++;
                $display("FAIL pending cyc=%0d got=%b exp=%b", e.cyc, cfg.pending, e.pending);
            end
            checks++;
            if (cfg.cfg_ready !== e.ready) begin
                errors++;
                $display("FAIL cfg_ready cyc=%0d ch=%0d got=%b exp=%b", e.cyc, cfg.cfg_ch, cfg.cfg_ready, e.ready);
            end
        end
    end

    initial begin
        exp_t e;
        bit   fire;
        areset = 1'b0;
        tx = '1;
        flip = '0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch = '0;
        cfg.cfg_src = '0;
        cfg.cfg_delay = '0;
        cfg.cfg_en = 1'b0;
        model_reset(-1);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge pclk);
            #1;
            areset = !(c < 3 || (c >= 1500 && c < 1503) || (c >= 2800 && c < 2802));

            if (c == 10) push_frame(0, 8'h55);
            for (int s = 0; s < NUM_CH; s++) begin
                if (c > 40 && txq[s].size() == 0 && $urandom_range(0, 39) == 0)
                    push_frame(s, 8'($urandom));
                tx[s] = (txq[s].size() > 0) ? txq[s].pop_front() : 1'b1;
                hist[s][c] = tx[s];
            end

            cfg.cfg_valid = (c >= 100) && ($urandom_range(0, 9) == 0);
            cfg.cfg_ch    = 2'($urandom_range(0, 3));
            cfg.cfg_src   = 2'($urandom_range(0, 3));
            cfg.cfg_delay = 4'($urandom_range(0, 15));
            cfg.cfg_en    = ($urandom_range(0, 3) != 0);
            if (c == 100) begin
                cfg.cfg_valid = 1'b1; cfg.cfg_ch = 2'd1; cfg.cfg_src = 2'd0;
                cfg.cfg_delay = 4'd5; cfg.cfg_en = 1'b1;
            end
`ifdef UART_LINK_FAULT_EN
            for (int d = 0; d < NUM_CH; d++) flip[d] = ($urandom_range(0, 15) == 0);
`endif

            e.cyc = c;
            if (!areset) begin
                e.rx = '1; e.pending = '0; e.ready = 1'b1;
            end else begin
                e.rx = m_rx;
                for (int d = 0; d < NUM_CH; d++) e.pending[d] = m_pend[d];
                e.ready = model_ready(int'(cfg.cfg_ch));
            end
            sb.push_back(e);

            fire = cfg.cfg_valid && areset && model_ready(int'(cfg.cfg_ch));
            model_step(c, fire, int'(cfg.cfg_ch), int'(cfg.cfg_src),
                       int'(cfg.cfg_delay), cfg.cfg_en);
        end

        repeat (2) @(posedge pclk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
